cic_comb: RTL and testbench
===========================

// Module: cic_comb
//
// PURPOSE
// Comb section of the CIC decimator; sits directly downstream of the downsampler.
// Consumes decimated samples (one per tvalid pulse), applies CIC_N cascaded comb
// stages y[n] = x[n] - x[n-CIC_M], then truncates the full-precision result to
// DATA_WIDTH_OUT. Fully pipelined: accepts one sample per clk, no backpressure.
//
// PARAMETERS
// DATA_WIDTH_INP  8   input width (full CIC register width, already grown by integrators)
// DATA_WIDTH_OUT  8   output width, <= DATA_WIDTH_INP; MSBs of final comb result are kept
// CIC_N           3   number of comb stages, >= 1
// CIC_M           1   differential delay in decimated samples, >= 1
//
// PORTS
// clk                in   1               clock
// reset_n            in   1               synchronous, active-low reset
// s_axis_in_tdata    in   DATA_WIDTH_INP  signed decimated sample
// s_axis_in_tvalid   in   1               sample qualifier; may be high any cycle, gaps allowed
// m_axis_out_tdata   out  DATA_WIDTH_OUT  signed filtered sample
// m_axis_out_tvalid  out  1               one-cycle pulse per output sample
//
// BEHAVIOUR
// - Reset (reset_n low at posedge clk): all delay-line taps, stage registers,
//   stage valids, m_axis_out_tdata and m_axis_out_tvalid cleared to 0.
// - Stage k (k=0..CIC_N-1): on its input valid, out_k <= in_k - dly_k[CIC_M-1];
//   dly_k shifts in in_k (dly_k[0] <= in_k). Delay line and out_k hold when valid low.
// - Stage valid register: v_k <= valid into stage k (not sticky; low when input low).
// - Latency: exactly CIC_N clk cycles from s_axis_in_tvalid to m_axis_out_tvalid;
//   output tdata registered in the last stage, truncation is a wire slice
//   [DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT] (no rounding).
// - Throughput: one sample per clk; back-to-back valids produce back-to-back outputs.
// - Arithmetic: all stages DATA_WIDTH_INP wide, two's complement, wrap modulo
//   2^DATA_WIDTH_INP (no saturation) -- required for correct CIC behaviour.
// - Valid gaps: output sample sequence identical to gap-free case; only timing shifts.
// - Start-up: first CIC_N*CIC_M outputs after reset contain the zero-history transient.
// - Reset mid-stream: in-flight samples discarded, no tvalid for them; history zeroed.
// - m_axis_out_tdata holds last value while m_axis_out_tvalid low.
//
// STRUCTURE
// - cic_pkg: shared defaults (CIC_N, CIC_M), width helper functions used by
//   integrator/downsampler/comb to derive DATA_WIDTH_INP = W_in + CIC_N*clog2(R*M).
// - Sub-module cic_comb_stage (WIDTH, CIC_M): one comb with delay line and valid
//   register; cic_comb instantiates CIC_N of them in a generate loop, plus slice.
//
// TESTING (CIC_N=3, CIC_M=1, widths 8/8 unless stated)
// - Impulse: 1,0,0,0,0 with valid every cycle -> outputs 1,-3,3,-1,0; first tvalid 3 clk after input.
// - Step: constant 5 -> outputs 5,-10,5,0,0,... then 0 forever.
// - Wrap: inputs 127,-128 -> stage 0 yields 127,-255 wrapped to 1; check final outputs
//   match 8-bit modulo reference model.
// - Valid gaps: impulse with random 0-3 idle cycles between samples -> same 1,-3,3,-1,0
//   sequence, tvalid count equals input valid count.
// - Reset mid-stream: reset_n low 1 cycle while 2 samples in flight -> no tvalid for
//   them; next impulse reproduces 1,-3,3,-1 exactly.
// - Truncation/delay: DATA_WIDTH_INP=12, DATA_WIDTH_OUT=8, CIC_M=2, CIC_N=1, input 0x100,
//   0,0 -> outputs 0x10,0x00,0xF0 (i.e. 16,0,-16).

Source files
------------

// File: rtl/cic_comb_pkg.sv
// Shared CIC defaults and width helpers used by the integrator, downsampler and comb sections.
package cic_comb_pkg;

  localparam int unsigned CIC_N_DEFAULT = 3;
  localparam int unsigned CIC_M_DEFAULT = 1;

  // Register growth through the integrators: W_in + N * clog2(R * M).
  function automatic int unsigned cic_width(input int unsigned w_in, input int unsigned n,
                                            input int unsigned r, input int unsigned m);
    return w_in + n * $clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_comb_if.sv
// Streaming sample bus (tdata/tvalid, no backpressure) between CIC sections.
interface cic_comb_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input tdata, input tvalid);
endinterface

// File: rtl/cic_comb_stage.sv
// One comb stage: y[n] = x[n] - x[n-CIC_M], modulo 2^WIDTH, one-cycle latency.
module cic_comb_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CIC_M = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [CIC_M-1:0][WIDTH-1:0] dly_q;
  logic [WIDTH-1:0]            out_q;
  logic                        valid_q;

  // Delay line advances only on valid samples, so idle gaps do not disturb history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dly_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        out_q    <= in_data - dly_q[CIC_M-1];
        dly_q[0] <= in_data;
        for (int i = int'(CIC_M) - 1; i > 0; i--) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end
  end

  assign out_data  = out_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/cic_comb.sv
// CIC decimator comb section: CIC_N cascaded comb stages followed by MSB truncation.
module cic_comb
  import cic_comb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_INP = 8,
  parameter int unsigned DATA_WIDTH_OUT = 8,
  parameter int unsigned CIC_N          = CIC_N_DEFAULT,
  parameter int unsigned CIC_M          = CIC_M_DEFAULT
) (
  input logic        clk,
  input logic        reset_n,
  cic_comb_if.slave  s_axis_in,
  cic_comb_if.master m_axis_out
);

  logic [CIC_N:0][DATA_WIDTH_INP-1:0] data;
  logic [CIC_N:0]                     valid;

  assign data[0]  = s_axis_in.tdata;
  assign valid[0] = s_axis_in.tvalid;

  for (genvar k = 0; k < CIC_N; k++) begin : g_stage
    cic_comb_stage #(
      .WIDTH (DATA_WIDTH_INP),
      .CIC_M (CIC_M)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (data[k]),
      .in_valid  (valid[k]),
      .out_data  (data[k+1]),
      .out_valid (valid[k+1])
    );
  end

  // Plain truncation: keep the MSBs, no rounding.
  assign m_axis_out.tdata  = data[CIC_N][DATA_WIDTH_INP-1 -: DATA_WIDTH_OUT];
  assign m_axis_out.tvalid = valid[CIC_N];

  if (DATA_WIDTH_OUT < DATA_WIDTH_INP) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^data[CIC_N][DATA_WIDTH_INP-DATA_WIDTH_OUT-1:0];
  end

endmodule

// File: tb/tb_cic_comb.sv
// Directed checks of the CIC comb section: N=3/M=1 at 8 bits, and N=1/M=2 truncating 12 to 8.
module tb_cic_comb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cic_comb_if #(.WIDTH(8))  in_a ();
  cic_comb_if #(.WIDTH(8))  out_a ();
  cic_comb_if #(.WIDTH(12)) in_b ();
  cic_comb_if #(.WIDTH(8))  out_b ();

  cic_comb #(
    .DATA_WIDTH_INP (8),
    .DATA_WIDTH_OUT (8),
    .CIC_N          (3),
    .CIC_M          (1)
  ) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_axis_in  (in_a),
    .m_axis_out (out_a)
  );

  cic_comb #(
    .DATA_WIDTH_INP (12),
    .DATA_WIDTH_OUT (8),
    .CIC_N          (1),
    .CIC_M          (2)
  ) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_axis_in  (in_b),
    .m_axis_out (out_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic signed [7:0] q_a[$];
  int                t_a[$];
  logic signed [7:0] q_b[$];
  int                t_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_a.tvalid === 1'b1) begin
      q_a.push_back(out_a.tdata);
      t_a.push_back(cyc);
    end
    if (out_b.tvalid === 1'b1) begin
      q_b.push_back(out_b.tdata);
      t_b.push_back(cyc);
    end
  end

  task automatic clear_queues();
    q_a.delete();
    t_a.delete();
    q_b.delete();
    t_b.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_n     = 1'b0;
    in_a.tvalid = 1'b0;
    in_b.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_queues();
  endtask

  task automatic send_a(input logic [7:0] d, output int stamp);
    @(posedge clk);
    #1;
    in_a.tdata  = d;
    in_a.tvalid = 1'b1;
    stamp       = cyc;
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_a.tvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    in_a.tdata  = 8'h55;
    in_a.tvalid = 1'b1;
    in_b.tdata  = 12'h3A5;
    in_b.tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (out_a.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_tvalid: got %b want 0", out_a.tvalid);
    end
    if (out_a.tdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_a_tdata: got %h want 00", out_a.tdata);
    end
    if (out_b.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_b_tvalid: got %b want 0", out_b.tvalid);
    end
    if (out_b.tdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_b_tdata: got %h want 00", out_b.tdata);
    end
    in_a.tvalid = 1'b0;
    in_b.tvalid = 1'b0;
    reset_n     = 1'b1;
    clear_queues();
  endtask

  task automatic test_impulse();
    logic signed [7:0] exp_v[5] = '{8'sd1, -8'sd3, 8'sd3, -8'sd1, 8'sd0};
    int t0;
    int ts;
    apply_reset();
    send_a(8'd1, t0);
    for (int i = 0; i < 4; i++) send_a(8'd0, ts);
    idle_a(6);
    checks++;
    if (q_a.size() != 5) begin
      errors++;
      $display("FAIL impulse_count: got %0d want 5", q_a.size());
    end
    for (int i = 0; i < 5 && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL impulse[%0d]: got %0d want %0d", i, q_a[i], exp_v[i]);
      end
    end
    if (t_a.size() == 5) begin
      checks += 2;
      if (t_a[0] - t0 != 3) begin
        errors++;
        $display("FAIL impulse_latency: got %0d want 3", t_a[0] - t0);
      end
      if (t_a[4] - t_a[0] != 4) begin
        errors++;
        $display("FAIL impulse_back_to_back: got span %0d want 4", t_a[4] - t_a[0]);
      end
    end
  endtask

  task automatic test_step();
    logic signed [7:0] exp_v[8] = '{8'sd5, -8'sd10, 8'sd5, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    int ts;
    apply_reset();
    for (int i = 0; i < 8; i++) send_a(8'd5, ts);
    idle_a(6);
    checks++;
    if (q_a.size() != 8) begin
      errors++;
      $display("FAIL step_count: got %0d want 8", q_a.size());
    end
    for (int i = 0; i < 8 && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL step[%0d]: got %0d want %0d", i, q_a[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic signed [7:0] in_v[6]  = '{8'sd127, -8'sd128, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    logic signed [7:0] exp_v[6] = '{8'sd127, 8'sd3, -8'sd3, 8'sd1, -8'sd128, 8'sd0};
    int ts;
    apply_reset();
    for (int i = 0; i < 6; i++) send_a(in_v[i], ts);
    idle_a(6);
    checks++;
    if (q_a.size() != 6) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 6", q_a.size());
    end
    for (int i = 0; i < 6 && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: got %0d want %0d", i, q_a[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_gaps();
    logic signed [7:0] exp_v[5] = '{8'sd1, -8'sd3, 8'sd3, -8'sd1, 8'sd0};
    int ts;
    int sent = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      idle_a(int'($urandom_range(0, 3)));
      send_a((i == 0) ? 8'd1 : 8'd0, ts);
      sent++;
    end
    idle_a(6);
    checks++;
    if (q_a.size() != sent) begin
      errors++;
      $display("FAIL gaps_count: got %0d want %0d", q_a.size(), sent);
    end
    for (int i = 0; i < 5 && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL gaps[%0d]: got %0d want %0d", i, q_a[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic signed [7:0] exp_v[4] = '{8'sd1, -8'sd3, 8'sd3, -8'sd1};
    int ts;
    apply_reset();
    send_a(8'd7, ts);
    send_a(8'd9, ts);
    @(posedge clk);
    #1;
    in_a.tvalid = 1'b0;
    reset_n     = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_a(5);
    checks++;
    if (q_a.size() != 0) begin
      errors++;
      $display("FAIL midreset_flush: got %0d outputs want 0", q_a.size());
    end
    clear_queues();
    send_a(8'd1, ts);
    for (int i = 0; i < 3; i++) send_a(8'd0, ts);
    idle_a(6);
    checks++;
    if (q_a.size() != 4) begin
      errors++;
      $display("FAIL midreset_count: got %0d want 4", q_a.size());
    end
    for (int i = 0; i < 4 && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL midreset[%0d]: got %0d want %0d", i, q_a[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_truncation();
    logic [11:0] in_v[3]  = '{12'h100, 12'h000, 12'h000};
    logic [7:0]  exp_v[3] = '{8'h10, 8'h00, 8'hF0};
    int t0 = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_b.tdata  = in_v[i];
      in_b.tvalid = 1'b1;
      if (i == 0) t0 = cyc;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      in_b.tvalid = 1'b0;
    end
    checks++;
    if (q_b.size() != 3) begin
      errors++;
      $display("FAIL trunc_count: got %0d want 3", q_b.size());
    end
    for (int i = 0; i < 3 && i < q_b.size(); i++) begin
      checks++;
      if (q_b[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL trunc[%0d]: got %h want %h", i, q_b[i], exp_v[i]);
      end
    end
    if (t_b.size() > 0) begin
      checks++;
      if (t_b[0] - t0 != 1) begin
        errors++;
        $display("FAIL trunc_latency: got %0d want 1", t_b[0] - t0);
      end
    end
    checks += 2;
    if (out_b.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL hold_tvalid: got %b want 0", out_b.tvalid);
    end
    if (out_b.tdata !== 8'hF0) begin
      errors++;
      $display("FAIL hold_tdata: got %h want f0", out_b.tdata);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    in_a.tdata  = '0;
    in_a.tvalid = 1'b0;
    in_b.tdata  = '0;
    in_b.tvalid = 1'b0;
    test_reset();
    test_impulse();
    test_step();
    test_wrap();
    test_gaps();
    test_reset_midstream();
    test_truncation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
